// File: rtl/lsu_req_ctrl_pkg.sv
// Shared definitions for the LSU request controller: MemOP and fault
// encodings, FSM state type, default data width and access counter width.
// Ports: none (package only).
package lsu_req_ctrl_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

  // Wide enough for the largest read latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_req_ctrl_if.sv
// Bundle of the three handshakes around the LSU request controller:
// execute-stage request, LSU control/data, and writeback response.
// slave = controller side, master = environment (execute/LSU/writeback) side.
interface lsu_req_ctrl_if
  import lsu_req_ctrl_pkg::*;
#(
  parameter int XLEN = LSU_XLEN,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic            in_wen;
  logic            in_ren;
  logic [2:0]      in_memop;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [RD_W-1:0] in_rd;

  logic            mem_write;
  logic            mem_read;
  logic [2:0]      mem_op;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rdata;
  logic [RD_W-1:0] out_rd;
  logic            out_is_load;
  logic [1:0]      out_fault;

  modport slave (
    input  in_valid, in_wen, in_ren, in_memop, in_addr, in_wdata, in_rd,
    input  mem_rdata, out_ready,
    output in_ready, mem_write, mem_read, mem_op, mem_addr, mem_wdata,
    output out_valid, out_rdata, out_rd, out_is_load, out_fault
  );

  modport master (
    output in_valid, in_wen, in_ren, in_memop, in_addr, in_wdata, in_rd,
    output mem_rdata, out_ready,
    input  in_ready, mem_write, mem_read, mem_op, mem_addr, mem_wdata,
    input  out_valid, out_rdata, out_rd, out_is_load, out_fault
  );
endinterface

// File: rtl/lsu_req_ctrl_memop_check.sv
// Combinational fault decode of a memory request (illegal op beats misalign).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: memop_i, wen_i, ren_i, addr_lo_i (addr[1:0]) in; fault_o out.
module lsu_req_ctrl_memop_check
  import lsu_req_ctrl_pkg::*;
(
  input  logic [2:0] memop_i,
  input  logic       wen_i,
  input  logic       ren_i,
  input  logic [1:0] addr_lo_i,
  output logic [1:0] fault_o
);
  logic illegal;
  logic misalign;

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    fault_o  = FAULT_NONE;
    case (memop_i)
      MEMOP_B, MEMOP_BU: misalign = 1'b0;
      MEMOP_H, MEMOP_HU: misalign = addr_lo_i[0];
      MEMOP_W:           misalign = (addr_lo_i != 2'b00);
      default:           illegal  = 1'b1;
    endcase
    // Unsigned variants only make sense for loads; wen wins over ren.
    if (wen_i && (memop_i == MEMOP_BU || memop_i == MEMOP_HU)) begin
      illegal = 1'b1;
    end
    // A request with neither wen nor ren is a no-op and never faults.
    if (wen_i || ren_i) begin
      if (illegal) begin
        fault_o = FAULT_ILLEGAL;
      end else if (misalign) begin
        fault_o = FAULT_MISALIGN;
      end
    end
  end
endmodule

// File: rtl/lsu_req_ctrl.sv
// Serialising request controller in front of the LSU: checks, drives, captures.
// Latency accept->out_valid: load RD_LAT+1, store 2, fault/no-op 1 cycle.
// Backpressure: in_ready only in IDLE; RESP holds all out_* until out_ready.
// Ports: clk, rst (async, active-low), bus (request, LSU and response sides).
module lsu_req_ctrl
  import lsu_req_ctrl_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int RD_LAT = 1,
  parameter int RD_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  lsu_req_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       mem_op_q, mem_op_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]  out_rdata_q, out_rdata_d;
  logic [RD_W-1:0]  out_rd_q, out_rd_d;
  logic             out_is_load_q, out_is_load_d;
  logic [1:0]       out_fault_q, out_fault_d;
  logic [1:0]       req_fault;
  logic             req_access;

  lsu_req_ctrl_memop_check u_memop_check (
    .memop_i   (bus.in_memop),
    .wen_i     (bus.in_wen),
    .ren_i     (bus.in_ren),
    .addr_lo_i (bus.in_addr[1:0]),
    .fault_o   (req_fault)
  );

  assign req_access = (req_fault == FAULT_NONE) && (bus.in_wen || bus.in_ren);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_store_d    = is_store_q;
    mem_op_d      = mem_op_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    out_rdata_d   = out_rdata_q;
    out_rd_d      = out_rd_q;
    out_is_load_d = out_is_load_q;
    out_fault_d   = out_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          is_store_d    = bus.in_wen;
          mem_op_d      = bus.in_memop;
          mem_addr_d    = bus.in_addr;
          mem_wdata_d   = bus.in_wdata;
          out_rd_d      = bus.in_rd;
          out_fault_d   = req_fault;
          out_is_load_d = !bus.in_wen && bus.in_ren && (req_fault == FAULT_NONE);
          cnt_d         = '0;
          state_d       = req_access ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (is_store_q) begin
          state_d = ST_RESP;
        end else if (cnt_q == LAST_CNT) begin
          // LSU data is valid during the final read cycle only.
          out_rdata_d = bus.mem_rdata;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          out_rdata_d   = '0;
          out_is_load_d = 1'b0;
          out_fault_d   = FAULT_NONE;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_store_q    <= 1'b0;
      mem_op_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      out_rdata_q   <= '0;
      out_rd_q      <= '0;
      out_is_load_q <= 1'b0;
      out_fault_q   <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_store_q    <= is_store_d;
      mem_op_q      <= mem_op_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      out_rdata_q   <= out_rdata_d;
      out_rd_q      <= out_rd_d;
      out_is_load_q <= out_is_load_d;
      out_fault_q   <= out_fault_d;
    end
  end

  // Strobes decode straight from reset flops so they fall the instant rst does.
  assign bus.mem_read    = (state_q == ST_ACCESS) && !is_store_q;
  assign bus.mem_write   = (state_q == ST_ACCESS) && is_store_q;
  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_RESP);
  assign bus.mem_op      = mem_op_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.out_rdata   = out_rdata_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_is_load = out_is_load_q;
  assign bus.out_fault   = out_fault_q;
endmodule
